// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a circular receive FIFO; the CPU reads the head
// byte and status through rd_data, and each pop consumes one byte.
module uart_rx_fifo #(
    parameter int CLOCK_HZ   = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        pop,
    output logic [15:0] rd_data,
    output logic        irq
);

    function automatic int round_div(input int num, input int den);
        return (num + den / 2) / den;
    endfunction

    localparam int DIV   = round_div(CLOCK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_fifo: CLOCK_HZ/BAUD must round to at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         mem_q [DEPTH];

    logic rxs;
    logic cnt_zero;
    logic push;
    logic fe_set;
    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic ovr_set;

    assign rxs      = sync_q[1];
    assign cnt_zero = (cnt_q == '0);
    assign sync_d   = {sync_q[0], rx};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Shift register and storage hold data only and are never reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= shift_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rxs) state_d = S_START;
            S_START: if (cnt_zero) state_d = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (cnt_zero) state_d = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bit timing: half a bit into the start bit, then one full bit per sample.
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                cnt_d     = CNT_W'(DIV / 2);
                bit_idx_d = 3'd0;
            end
            S_START, S_DATA, S_STOP: begin
                cnt_d = cnt_zero ? CNT_W'(DIV - 1) : cnt_q - 1'b1;
                if (state_q == S_DATA && cnt_zero) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Output strobes
    always_comb begin
        push   = 1'b0;
        fe_set = 1'b0;
        if (state_q == S_STOP && cnt_zero) begin
            push   = rxs;
            fe_set = !rxs;
        end
    end

    // FIFO bookkeeping; a pop on a full FIFO frees the slot the push needs.
    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                      (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        do_pop      = pop && !empty;
        do_push     = push && (!full || pop);
        ovr_set     = push && full && !pop;
        wr_ptr_d    = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
        rd_ptr_d    = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
        overrun_d   = ovr_set ? 1'b1 : (pop ? 1'b0 : overrun_q);
        frame_err_d = fe_set  ? 1'b1 : (pop ? 1'b0 : frame_err_q);
    end

    assign irq     = !empty;
    assign rd_data = {5'b0, frame_err_q, overrun_q, !empty,
                      empty ? 8'h00 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]]};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, expected rd_data
// taken from a queue-based model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;

    localparam int CLOCK_HZ  = 100_000;
    localparam int BAUD      = 10_000;
    localparam int DIV       = 10;
    localparam int DEPTH     = 16;
    // The pin is driven just after edge 0, so edge 1 is the first to see it;
    // the byte is visible after 9.5*DIV+3 further edges.
    localparam int PUSH_EDGE = (19 * DIV) / 2 + 3 + 1;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        pop;
    logic [15:0] rd_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;

    uart_rx_fifo #(
        .CLOCK_HZ  (CLOCK_HZ),
        .BAUD      (BAUD),
        .DEPTH_LOG2(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .pop    (pop),
        .rd_data(rd_data),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] exp_rd();
        logic ne;
        ne = (q.size() != 0);
        return {5'b0, m_fe, m_ovr, ne, ne ? q[0] : 8'h00};
    endfunction

    // One clock edge of the model: pop clears flags, a set on the same edge wins.
    task automatic m_edge(input bit push_ok, input bit fe, input logic [7:0] b, input bit popv);
        bit do_pop;
        bit accept;
        do_pop = popv && q.size() > 0;
        accept = push_ok && (q.size() < DEPTH || popv);
        if (popv) begin
            m_ovr = 1'b0;
            m_fe  = 1'b0;
        end
        if (fe) m_fe = 1'b1;
        if (push_ok && !accept) m_ovr = 1'b1;
        if (do_pop) void'(q.pop_front());
        if (accept) q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pop_at_push);
        int total;
        total = 9 * DIV + stop_low + DIV;
        for (int c = 0; c < total; c++) begin
            if (c < DIV)                     rx = 1'b0;
            else if (c < 9 * DIV)            rx = b[c / DIV - 1];
            else if (c < 9 * DIV + stop_low) rx = 1'b0;
            else                             rx = 1'b1;
            pop = pop_at_push && (c == PUSH_EDGE - 1);
            @(posedge clk);
            #1;
        end
        pop = 1'b0;
        m_edge(stop_low == 0, stop_low != 0, b, pop_at_push);
        tick($urandom_range(0, 3));
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        m_edge(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        pop = 1'b0;
        tick(3);
        n_checks++;
        if (rd_data !== 16'h0000 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rd_data=%h irq=%b expected 0000/0", rd_data, irq);
        end
        rst = 1'b0;
        tick(5);
        n_checks++;
        if (rd_data !== exp_rd() || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: rd_data=%h irq=%b expected %h/0", rd_data, irq, exp_rd());
        end
    endtask

    task automatic test_basic();
        int cyc;
        cyc = 0;
        fork
            send_frame(8'h41, 0, 1'b0);
            begin
                while (irq !== 1'b1 && cyc < 200) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
            end
        join
        n_checks++;
        if (cyc !== PUSH_EDGE) begin
            n_fail++;
            $display("FAIL basic_latency: irq rose after %0d cycles expected %0d", cyc, PUSH_EDGE);
        end
        n_checks++;
        if (rd_data !== exp_rd() || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_rx: rd_data=%h irq=%b expected %h/1", rd_data, irq, exp_rd());
        end
        do_pop();
        n_checks++;
        if (rd_data !== exp_rd() || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: rd_data=%h irq=%b expected %h/0", rd_data, irq, exp_rd());
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * DIV);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL glitch_no_push: rd_data=%h expected %h", rd_data, exp_rd());
        end
        send_frame(8'h5A, 0, 1'b0);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL glitch_next_frame: rd_data=%h expected %h", rd_data, exp_rd());
        end
        do_pop();
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 0, 1'b0);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL overrun_set: rd_data=%h expected %h", rd_data, exp_rd());
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            n_checks++;
            if (rd_data !== exp_rd() || irq !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL overrun_drain[%0d]: rd_data=%h irq=%b expected %h", i, rd_data, irq, exp_rd());
            end
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h33, 2 * DIV, 1'b0);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL frame_err_set: rd_data=%h expected %h", rd_data, exp_rd());
        end
        do_pop();
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL frame_err_clear: rd_data=%h expected %h", rd_data, exp_rd());
        end
        send_frame(8'h34, 0, 1'b0);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL frame_err_next: rd_data=%h expected %h", rd_data, exp_rd());
        end
        do_pop();
    endtask

    task automatic test_full_simul();
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 1'b0);
        last = 8'($urandom_range(0, 255));
        send_frame(last, 0, 1'b1);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL full_simul_status: rd_data=%h expected %h", rd_data, exp_rd());
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== exp_rd()) begin
                n_fail++;
                $display("FAIL full_simul_drain[%0d]: rd_data=%h expected %h", i, rd_data, exp_rd());
            end
            if (i == DEPTH - 1) begin
                n_checks++;
                if (rd_data[7:0] !== last) begin
                    n_fail++;
                    $display("FAIL full_simul_last: head=%h expected %h", rd_data[7:0], last);
                end
            end
            do_pop();
        end
        n_checks++;
        if (rd_data !== 16'h0000 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL full_simul_empty: rd_data=%h irq=%b expected 0000/0", rd_data, irq);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hA5;
        for (int c = 0; c < 5 * DIV + DIV / 2; c++) begin
            rx = (c < DIV) ? 1'b0 : b[c / DIV - 1];
            tick(1);
        end
        rst = 1'b1;
        rx  = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(12 * DIV);
        n_checks++;
        if (rd_data !== exp_rd() || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_no_partial: rd_data=%h irq=%b expected %h/0", rd_data, irq, exp_rd());
        end
        send_frame(8'h7E, 0, 1'b0);
        n_checks++;
        if (rd_data !== exp_rd()) begin
            n_fail++;
            $display("FAIL midframe_next: rd_data=%h expected %h", rd_data, exp_rd());
        end
        do_pop();
        n_checks++;
        if (rd_data !== exp_rd() || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_only_one: rd_data=%h irq=%b expected %h/0", rd_data, irq, exp_rd());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom_range(0, 255)), 0, 1'b0);
            if ($urandom_range(0, 1) == 1) do_pop();
            n_checks++;
            if (rd_data !== exp_rd() || irq !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL random[%0d]: rd_data=%h irq=%b expected %h", i, rd_data, irq, exp_rd());
            end
        end
        while (q.size() != 0) do_pop();
        n_checks++;
        if (rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL random_drain: rd_data=%h expected 0000", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_full_simul();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
